mc_sdp_ram: RTL and testbench

- Simple-dual-port synchronous RAM that sits directly downstream of the memory controller.
- Serves the controller's load port (address/enable out, data back) and store port (enable/address/data out).
- Fixed 1-cycle read latency, matching the controller's registered read-select timing.
- Adds a post-reset clear engine and a host/test port so benches can preload and dump memory while the dataflow circuit is idle.

---
 rtl/mc_mem_pkg.sv | 23 ++
 rtl/mc_ram_core.sv | 27 ++
 rtl/mc_sdp_ram.sv | 132 +++++++++++++
 tb/tb_mc_sdp_ram.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// rtl/mc_mem_pkg.sv - shared types and sizing helpers for the controller-side RAM
package mc_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    DONE  = 1'b1
  } clr_state_t;

  localparam int DEFAULT_DEPTH = 1024;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Index width never collapses to zero, even for a one-word memory.
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/mc_ram_core.sv
// rtl/mc_ram_core.sv - DEPTH x DATA_SIZE array, one synchronous read port, one write port
module mc_ram_core #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 1024,
  parameter int IDX       = 10
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [IDX-1:0]       raddr,
  input  logic                 we,
  input  logic [IDX-1:0]       waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first: a same-edge write to the read address is forwarded.
  always_ff @(posedge clk) begin
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/mc_sdp_ram.sv
// rtl/mc_sdp_ram.sv - memory-controller RAM with post-reset clear and host/test port
module mc_sdp_ram
  import mc_mem_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int ADDRESS_SIZE   = 32,
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic [ADDRESS_SIZE-1:0] load_addr,
  output logic [DATA_SIZE-1:0]    load_data,
  input  logic                    store_en,
  input  logic [ADDRESS_SIZE-1:0] store_addr,
  input  logic [DATA_SIZE-1:0]    store_data,
  input  logic                    host_en,
  input  logic                    host_we,
  input  logic [ADDRESS_SIZE-1:0] host_addr,
  input  logic [DATA_SIZE-1:0]    host_wdata,
  output logic                    host_ready,
  output logic [DATA_SIZE-1:0]    host_rdata,
  output logic                    host_rvalid,
  output logic                    init_done,
  output logic                    addr_err,
  output logic [31:0]             store_count
);

  localparam int IDX = idx_width(DEPTH);

  function automatic logic in_range(input logic [ADDRESS_SIZE-1:0] a);
    return a < ADDRESS_SIZE'(DEPTH);
  endfunction

  clr_state_t           state;
  logic [IDX-1:0]       clear_idx;
  logic                 load_ok, store_ok, host_ok;
  logic                 host_acc, host_rd_acc, host_wr_acc, store_acc;
  logic                 ram_re, ram_we;
  logic [IDX-1:0]       ram_raddr, ram_waddr;
  logic [DATA_SIZE-1:0] ram_wdata, ram_rdata;
  logic                 load_vld_q, load_ok_q, host_ok_q;
  logic [DATA_SIZE-1:0] load_hold_q, host_hold_q;

  assign load_ok     = init_done & in_range(load_addr);
  assign store_ok    = init_done & in_range(store_addr);
  assign host_ok     = in_range(host_addr);
  assign host_ready  = init_done & ~(host_we ? store_en : load_en);
  assign host_acc    = host_en & host_ready;
  assign host_rd_acc = host_acc & ~host_we;
  assign host_wr_acc = host_acc & host_we & host_ok;
  assign store_acc   = store_en & store_ok;

  assign ram_re    = (load_en & load_ok) | (host_rd_acc & host_ok);
  assign ram_raddr = load_en ? load_addr[IDX-1:0] : host_addr[IDX-1:0];

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = host_addr[IDX-1:0];
    ram_wdata = host_wdata;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clear_idx;
      ram_wdata = '0;
    end else if (store_acc) begin
      ram_we    = 1'b1;
      ram_waddr = store_addr[IDX-1:0];
      ram_wdata = store_data;
    end else if (host_wr_acc) begin
      ram_we    = 1'b1;
    end
  end

  mc_ram_core #(
    .DATA_SIZE(DATA_SIZE),
    .DEPTH    (DEPTH),
    .IDX      (IDX)
  ) u_core (
    .clk  (clk),
    .re   (ram_re),
    .raddr(ram_raddr),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : DONE;
      clear_idx <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= init_done | (state == DONE);
      if (state == CLEAR) begin
        clear_idx <= clear_idx + 1'b1;
        if (clear_idx == IDX'(DEPTH - 1)) state <= DONE;
      end
    end
  end

  // The core output is shared by both readers, so each keeps its last shown value.
  always_comb begin
    load_data  = load_vld_q ? (load_ok_q ? ram_rdata : '0) : load_hold_q;
    host_rdata = host_rvalid ? (host_ok_q ? ram_rdata : '0) : host_hold_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_vld_q  <= 1'b0;
      load_ok_q   <= 1'b0;
      load_hold_q <= '0;
      host_rvalid <= 1'b0;
      host_ok_q   <= 1'b0;
      host_hold_q <= '0;
      addr_err    <= 1'b0;
      store_count <= '0;
    end else begin
      load_vld_q  <= load_en;
      load_ok_q   <= load_ok;
      load_hold_q <= load_data;
      host_rvalid <= host_rd_acc;
      host_ok_q   <= host_ok;
      host_hold_q <= host_rdata;
      if ((load_en & ~load_ok) | (store_en & ~store_ok) | (host_acc & ~host_ok))
        addr_err <= 1'b1;
      if (store_acc) store_count <= store_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mc_sdp_ram.sv
// tb/tb_mc_sdp_ram.sv - directed self-checking bench for mc_sdp_ram (DEPTH=16)
module tb_mc_sdp_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b0, store_en = 1'b0, host_en = 1'b0, host_we = 1'b0;
  logic [31:0] load_addr = '0, store_addr = '0, store_data = '0;
  logic [31:0] host_addr = '0, host_wdata = '0;
  logic [31:0] load_data, host_rdata, store_count;
  logic        host_ready, host_rvalid, init_done, addr_err;

  int checks = 0;
  int errors = 0;

  mc_sdp_ram #(
    .DATA_SIZE(32), .ADDRESS_SIZE(32), .DEPTH(16), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .store_en(store_en), .store_addr(store_addr), .store_data(store_data),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .init_done(init_done), .addr_err(addr_err),
    .store_count(store_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a);
    load_en = 1'b1; load_addr = a;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    store_en = 1'b1; store_addr = a; store_data = d;
    tick();
    store_en = 1'b0;
  endtask

  task automatic host_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    host_en = 1'b1; host_we = 1'b0; host_addr = a; n = 0;
    while (!host_ready && n < 20) begin tick(); n++; end
    check("host_rd_ready", {31'd0, host_ready}, 32'd1);
    tick();
    host_en = 1'b0;
    check("host_rvalid", {31'd0, host_rvalid}, 32'd1);
    d = host_rdata;
  endtask

  // Counts edges from reset release to init_done; optional store on the first edge.
  task automatic release_and_count(input logic store_first, output int cnt);
    rst = 1'b1;
    if (store_first) begin
      store_en = 1'b1; store_addr = 32'd2; store_data = 32'h5A5A5A5A;
    end
    cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      store_en = 1'b0;
      if (init_done) begin cnt = n; break; end
    end
  endtask

  initial begin
    logic [31:0] d, acc;
    int cnt;

    tick(); tick();
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_store_count", store_count, 32'd0);
    check("rst_addr_err", {31'd0, addr_err}, 32'd0);
    check("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("rst_host_rdata", host_rdata, 32'd0);

    release_and_count(1'b0, cnt);
    check("init_latency", cnt, 32'd17);

    acc = '0;
    for (int a = 0; a < 16; a++) begin
      host_read(a, d);
      acc = acc | d;
    end
    check("clear_all_zero", acc, 32'd0);

    do_store(32'd5, 32'hDEADBEEF);
    do_load(32'd5);
    check("load_after_store", load_data, 32'hDEADBEEF);
    check("store_count_1", store_count, 32'd1);
    tick();
    check("load_data_held", load_data, 32'hDEADBEEF);

    do_store(32'd3, 32'hAAAA5555);
    load_en = 1'b1; load_addr = 32'd3;
    do_store(32'd3, 32'h12345678);
    load_en = 1'b0;
    check("rdw_write_first", load_data, 32'h12345678);
    do_load(32'd3);
    check("rdw_reload", load_data, 32'h12345678);
    check("store_count_3", store_count, 32'd3);

    load_en = 1'b1; load_addr = 32'd7;
    host_en = 1'b1; host_we = 1'b1; host_addr = 32'd7; host_wdata = 32'hCAFEF00D;
    #1;
    check("host_wr_ready_with_load", {31'd0, host_ready}, 32'd1);
    tick();
    load_en = 1'b0; host_en = 1'b0; host_we = 1'b0;
    check("host_wr_forward", load_data, 32'hCAFEF00D);
    check("host_wr_no_count", store_count, 32'd3);

    load_en = 1'b1; load_addr = 32'd5;
    do_store(32'd9, 32'h0BADC0DE);
    load_en = 1'b0;
    check("dual_load", load_data, 32'hDEADBEEF);
    do_load(32'd9);
    check("dual_store", load_data, 32'h0BADC0DE);
    check("store_count_4", store_count, 32'd4);
    check("no_err_yet", {31'd0, addr_err}, 32'd0);

    load_en = 1'b1; load_addr = 32'd16;
    do_store(32'd20, 32'h11111111);
    load_en = 1'b0;
    check("oor_load_zero", load_data, 32'd0);
    check("oor_addr_err", {31'd0, addr_err}, 32'd1);
    check("oor_store_count", store_count, 32'd4);
    do_load(32'd4);
    check("oor_store_no_alias", load_data, 32'd0);
    do_load(32'h00010005);
    check("oor_upper_bits", load_data, 32'd0);
    do_load(32'd5);
    check("oor_mem_intact", load_data, 32'hDEADBEEF);
    tick(); tick();
    check("addr_err_sticky", {31'd0, addr_err}, 32'd1);

    host_en = 1'b1; host_we = 1'b0; host_addr = 32'd9;
    load_en = 1'b1; load_addr = 32'd3;
    #1;
    check("host_rd_blocked", {31'd0, host_ready}, 32'd0);
    tick();
    load_en = 1'b0;
    check("host_no_rvalid", {31'd0, host_rvalid}, 32'd0);
    check("load_beside_host", load_data, 32'h12345678);
    #1;
    check("host_rd_unblocked", {31'd0, host_ready}, 32'd1);
    tick();
    host_en = 1'b0;
    check("host_rvalid_pulse", {31'd0, host_rvalid}, 32'd1);
    check("host_rdata", host_rdata, 32'h0BADC0DE);
    check("load_held_over_host", load_data, 32'h12345678);
    tick();
    check("host_rvalid_drop", {31'd0, host_rvalid}, 32'd0);

    host_en = 1'b1; host_we = 1'b1; host_addr = 32'd11; store_en = 1'b1;
    #1;
    check("host_wr_blocked", {31'd0, host_ready}, 32'd0);
    host_en = 1'b0; host_we = 1'b0; store_en = 1'b0;

    rst = 1'b0;
    tick();
    release_and_count(1'b0, cnt);
    check("reclear_latency", cnt, 32'd17);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0;
    #1;
    check("midclear_reset", {31'd0, init_done}, 32'd0);
    tick();
    release_and_count(1'b1, cnt);
    check("restart_latency", cnt, 32'd17);
    check("clear_store_err", {31'd0, addr_err}, 32'd1);
    check("clear_store_count", store_count, 32'd0);
    do_load(32'd2);
    check("clear_store_dropped", load_data, 32'd0);
    do_load(32'd3);
    check("recleared_3", load_data, 32'd0);
    do_load(32'd9);
    check("recleared_9", load_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
